// File: rtl/uart_frame_gen_pkg.sv
// uart_frame_gen_pkg: shared encodings, FSM states and frame packing for the UART frame generator
package uart_frame_gen_pkg;
  localparam int FRAME_W = 11;
  localparam logic [FRAME_W-1:0] IDLE_FRAME = 11'h7FF;
  typedef enum logic [1:0] {PAR_NONE = 2'b00, PAR_ODD = 2'b01, PAR_EVEN = 2'b10, PAR_PARALLEL = 2'b11} parity_e;
  typedef enum logic [1:0] {IDLE, LOAD, WAIT_DONE} state_e;
  function automatic logic [FRAME_W-1:0] pack_frame(input logic [7:0] data, input logic [1:0] parity_type,
                                                    input logic stop_bits, input logic data_length);
    logic [FRAME_W-1:0] f;
    logic [7:0] r;
    logic par;
    logic [3:0] p;
    r = {<<{data}};
    f = IDLE_FRAME;
    f[FRAME_W-1] = 1'b0;
    f[9:2] = data_length ? r : {r[7:1], 1'b1};
    par = data_length ? ^data : ^data[6:0];
    p = data_length ? 4'd1 : 4'd2;
    if (parity_type == PAR_ODD || parity_type == PAR_EVEN) begin
      f[p] = (parity_type == PAR_ODD) ? ~par : par;
      p = p - 4'd1;
    end
    // Stop bits land on the all-ones pad; a second stop bit past bit 0 is dropped.
    f[p] = 1'b1;
    if (stop_bits && p > 4'd0) f[p-4'd1] = 1'b1;
    return f;
  endfunction
endpackage

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: synchronous byte FIFO with full/empty flags; a full FIFO blocks push even when popping
module uart_tx_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] wr_data,
  input  logic       wr_en,
  input  logic       rd_en,
  output logic [7:0] rd_data,
  output logic       full,
  output logic       empty
);
  localparam int AW = $clog2(DEPTH);
  logic [7:0] mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic push;
  assign push = wr_en && !full;
  assign empty = wr_ptr == rd_ptr;
  assign full = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rd_data = mem[rd_ptr[AW-1:0]];
  always_ff @(posedge clk)
    if (push) mem[wr_ptr[AW-1:0]] <= wr_data;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en && !empty) rd_ptr <= rd_ptr + 1'b1;
    end
endmodule

// File: rtl/uart_frame_gen.sv
// uart_frame_gen: packs bytes into 11-bit UART frames and paces them against the shifter's tx_done.
// Define UART_TXQ_FIFO_EN to place a FIFO_DEPTH-entry byte FIFO in front of the FSM.
module uart_frame_gen
  import uart_frame_gen_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic               baud_out,
  input  logic               rst,
  input  logic [7:0]         data_in,
  input  logic               data_valid,
  output logic               data_ready,
  input  logic [1:0]         parity_type,
  input  logic               stop_bits,
  input  logic               data_length,
  input  logic               tx_done,
  output logic [FRAME_W-1:0] frame_out,
  output logic               send,
  output logic               busy,
  output logic [7:0]         frame_count
);
  state_e state;
  logic avail, take;
  logic [7:0] byte_q;
  if (FIFO_DEPTH < 2 || FIFO_DEPTH > 16 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of two in 2..16");
  end
`ifdef UART_TXQ_FIFO_EN
  logic full, empty;
  uart_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(baud_out), .rst(rst), .wr_data(data_in), .wr_en(data_valid), .rd_en(take),
    .rd_data(byte_q), .full(full), .empty(empty)
  );
  assign data_ready = !full;
  assign avail = !empty;
`else
  assign data_ready = state == IDLE;
  assign avail = data_valid;
  assign byte_q = data_in;
`endif
  assign take = state == IDLE && avail;
  assign send = state == LOAD;
  assign busy = state != IDLE;
  always_ff @(posedge baud_out or posedge rst)
    if (rst) begin
      state <= IDLE;
      frame_out <= IDLE_FRAME;
      frame_count <= '0;
    end else if (take) begin
      frame_out <= pack_frame(byte_q, parity_type, stop_bits, data_length);
      state <= LOAD;
    end else if (state == LOAD) begin
      state <= WAIT_DONE;
    end else if (state == WAIT_DONE && tx_done) begin
      frame_count <= frame_count + 8'd1;
      state <= IDLE;
    end
endmodule

// File: tb/tb_uart_frame_gen.sv
// tb_uart_frame_gen: directed self-checking bench for uart_frame_gen (FIFO checks when UART_TXQ_FIFO_EN is defined)
module tb_uart_frame_gen;
  logic baud_out = 1'b0, rst = 1'b1;
  logic [7:0] data_in = '0;
  logic data_valid = 1'b0, data_ready;
  logic [1:0] parity_type = 2'b00;
  logic stop_bits = 1'b0, data_length = 1'b1, tx_done = 1'b0;
  logic [10:0] frame_out;
  logic send, busy;
  logic [7:0] frame_count;
  int checks = 0, failures = 0;
  logic [7:0] fc = '0;

  uart_frame_gen #(.FIFO_DEPTH(4)) dut (
    .baud_out(baud_out), .rst(rst), .data_in(data_in), .data_valid(data_valid), .data_ready(data_ready),
    .parity_type(parity_type), .stop_bits(stop_bits), .data_length(data_length), .tx_done(tx_done),
    .frame_out(frame_out), .send(send), .busy(busy), .frame_count(frame_count)
  );

  always #5 baud_out = ~baud_out;

  task automatic tick;
    @(posedge baud_out);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic launch(input logic [7:0] d, input logic [1:0] pt, input logic sb, input logic dl);
    int n = 0;
    data_in = d;
    parity_type = pt;
    stop_bits = sb;
    data_length = dl;
    data_valid = 1'b1;
    while (!data_ready && n < 10) begin tick; n++; end
    chk("ready_seen", data_ready, 1);
    tick;
    data_valid = 1'b0;
    n = 0;
    while (!send && n < 6) begin tick; n++; end
    chk("send_seen", send, 1);
  endtask

  task automatic finish_frame;
    tx_done = 1'b1;
    tick;
    tx_done = 1'b0;
    fc++;
  endtask

  task automatic frame(input string tag, input logic [7:0] d, input logic [1:0] pt, input logic sb,
                       input logic dl, input logic [10:0] exp);
    launch(d, pt, sb, dl);
    chk(tag, frame_out, exp);
    chk("busy_load", busy, 1);
    tick;
    chk("send_one_cycle", send, 0);
    chk("busy_wait", busy, 1);
    tick;
    chk("frame_held", frame_out, exp);
    finish_frame;
    chk("busy_done", busy, 0);
    chk("count", frame_count, fc);
  endtask

  initial begin
    tick;
    tick;
    rst = 1'b0;
    chk("rst_frame", frame_out, 11'h7FF);
    chk("rst_send", send, 0);
    chk("rst_busy", busy, 0);
    chk("rst_count", frame_count, 0);
    chk("rst_ready", data_ready, 1);

    frame("8N1_A5", 8'hA5, 2'b00, 1'b0, 1'b1, 11'h297);
    frame("8E1_A5", 8'hA5, 2'b10, 1'b0, 1'b1, 11'h295);
    frame("7O2_41", 8'h41, 2'b01, 1'b1, 1'b0, 11'h20F);
    frame("8O2_FF", 8'hFF, 2'b01, 1'b1, 1'b1, 11'h3FF);
    frame("7P1_C1", 8'hC1, 2'b11, 1'b0, 1'b0, 11'h20F);

    tx_done = 1'b1;
    tick;
    tx_done = 1'b0;
    chk("spur_busy", busy, 0);
    chk("spur_count", frame_count, fc);
    tick;
    chk("spur_send", send, 0);

`ifdef UART_TXQ_FIFO_EN
    launch(8'hA5, 2'b00, 1'b0, 1'b1);
    chk("fifo_first", frame_out, 11'h297);
    for (int i = 1; i <= 4; i++) begin
      data_in = 8'(i);
      data_valid = 1'b1;
      tick;
    end
    data_valid = 1'b0;
    chk("fifo_full_ready", data_ready, 0);
    chk("fifo_still_busy", busy, 1);
    begin
      logic [10:0] exp_q [4] = '{11'h203, 11'h103, 11'h303, 11'h083};
      for (int i = 0; i < 4; i++) begin
        int n = 0;
        finish_frame;
        while (!send && n < 6) begin tick; n++; end
        chk("fifo_send_seen", send, 1);
        chk("fifo_order", frame_out, exp_q[i]);
        chk("fifo_count", frame_count, fc);
      end
    end
    chk("fifo_ready_again", data_ready, 1);
    finish_frame;
`else
    launch(8'hA5, 2'b00, 1'b0, 1'b1);
    tick;
    chk("busy_not_ready", data_ready, 0);
    data_in = 8'hFF;
    data_valid = 1'b1;
    tick;
    tick;
    chk("busy_no_accept", frame_out, 11'h297);
    data_valid = 1'b0;
    finish_frame;
    chk("idle_ready", data_ready, 1);
`endif
    chk("pre_rst_count", frame_count, fc);

    launch(8'hA5, 2'b00, 1'b0, 1'b1);
`ifdef UART_TXQ_FIFO_EN
    data_in = 8'h55;
    data_valid = 1'b1;
    tick;
    data_valid = 1'b0;
`else
    tick;
`endif
    chk("mid_busy", busy, 1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_frame", frame_out, 11'h7FF);
    chk("mid_rst_send", send, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_count", frame_count, 0);
    chk("mid_rst_ready", data_ready, 1);
    fc = '0;
    @(negedge baud_out);
    rst = 1'b0;
    tick;
    tick;
    tick;
    chk("post_rst_idle", busy, 0);
    frame("post_rst_8N1_01", 8'h01, 2'b00, 1'b0, 1'b1, 11'h203);

    for (int i = 0; i < 254; i++) begin
      launch(8'(i), 2'b00, 1'b0, 1'b1);
      tick;
      finish_frame;
    end
    chk("count_255", frame_count, 8'd255);
    frame("wrap_8N1_02", 8'h02, 2'b00, 1'b0, 1'b1, 11'h103);
    chk("count_wrap", frame_count, 8'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
